// File: rtl/cevero_dvfs_pkg.sv
// -----------------------------------------------------------------------------
// cevero_dvfs_pkg
// Shared types and default widths for the voltage/frequency sequencer.
//   seq_state_t  : sequencer FSM states
//   DEF_VOLT_W   : default width of the voltage code
//   DEF_FREQ_W   : default width of the frequency word
// -----------------------------------------------------------------------------
package cevero_dvfs_pkg;

   localparam int DEF_VOLT_W = 3;
   localparam int DEF_FREQ_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_V_UP  = 3'd1,
      ST_F_REQ = 3'd2,
      ST_V_DN  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

endpackage : cevero_dvfs_pkg

// File: rtl/cevero_settle_timer.sv
// -----------------------------------------------------------------------------
// cevero_settle_timer
// Loadable count-down timer. load_i stores load_val_i; each enabled cycle the
// count drops by one and saturates at zero. done_o is high while the count is
// at or below one, i.e. during the last cycle of an N-cycle interval, so the
// owner can leave its wait state on exactly the N-th edge after the load.
//   clk_i      : clock
//   rst_i      : synchronous reset, active-high
//   load_i     : load the counter (has priority over en_i)
//   load_val_i : value to load (number of cycles to wait, >= 1)
//   en_i       : count enable
//   done_o     : terminal-cycle flag
// -----------------------------------------------------------------------------
module cevero_settle_timer #(
   parameter int W = 5
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         done_o
);

   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] ZERO = W'(0);

   logic [W-1:0] r_cnt;

   // Counter register: load, saturating decrement, or hold.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= ZERO;
      end else if (load_i) begin
         r_cnt <= load_val_i;
      end else if (en_i && (r_cnt != ZERO)) begin
         r_cnt <= r_cnt - ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign done_o = (r_cnt <= ONE);

endmodule : cevero_settle_timer

// File: rtl/cevero_vf_sequencer.sv
// -----------------------------------------------------------------------------
// cevero_vf_sequencer
// Applies voltage/frequency requests in a safe order: raising voltage goes
// voltage first (then settle, then frequency); lowering goes frequency first
// (req/ack handshake) then voltage (then settle). A missing ack restores the
// previous frequency, leaves the voltage alone and raises a sticky fault.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_voltage_i/req_freq_i: requested operating point
//   def_voltage_i/def_freq_i: operating point applied during reset
//   vdd_sel_o / freq_sel_o  : applied voltage code / frequency word
//   freq_req_o / freq_ack_i : clock generator handshake
//   busy_o                  : sequence in progress
//   done_o                  : one-cycle pulse at sequence end
//   fault_o                 : sticky ack-timeout flag
// -----------------------------------------------------------------------------
module cevero_vf_sequencer
   import cevero_dvfs_pkg::*;
#(
   parameter int VOLT_W        = DEF_VOLT_W,
   parameter int FREQ_W        = DEF_FREQ_W,
   parameter int SETTLE_CYCLES = 16,
   parameter int ACK_TIMEOUT   = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [VOLT_W-1:0] req_voltage_i,
   input  logic [FREQ_W-1:0] req_freq_i,
   input  logic [VOLT_W-1:0] def_voltage_i,
   input  logic [FREQ_W-1:0] def_freq_i,
   output logic [VOLT_W-1:0] vdd_sel_o,
   output logic [FREQ_W-1:0] freq_sel_o,
   output logic              freq_req_o,
   input  logic              freq_ack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              fault_o
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_LD = TW'(ACK_TIMEOUT);

   seq_state_t        r_state, w_state_nx;
   logic [VOLT_W-1:0] r_vdd_sel, w_vdd_nx;
   logic [FREQ_W-1:0] r_freq_sel, w_freq_nx;
   logic              r_freq_req, w_req_nx;
   logic              r_fault, w_fault_nx;
   logic              r_busy, r_done;
   logic [VOLT_W-1:0] r_tgt_v, w_tgt_v_nx;
   logic [FREQ_W-1:0] r_tgt_f, w_tgt_f_nx;
   logic [FREQ_W-1:0] r_prev_f, w_prev_f_nx;
   logic              w_settle_load, w_settle_en, w_settle_done;
   logic              w_to_load, w_to_en, w_to_done;

   assign w_settle_en = (r_state == ST_V_UP) || (r_state == ST_V_DN);
   assign w_to_en     = (r_state == ST_F_REQ);

   cevero_settle_timer #(.W(SW)) u_settle (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (w_settle_load),
      .load_val_i (SETTLE_LD),
      .en_i       (w_settle_en),
      .done_o     (w_settle_done)
   );

   cevero_settle_timer #(.W(TW)) u_timeout (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (w_to_load),
      .load_val_i (TIMEOUT_LD),
      .en_i       (w_to_en),
      .done_o     (w_to_done)
   );

   // Next-state and next-output logic.
   always_comb begin
      w_state_nx    = r_state;
      w_vdd_nx      = r_vdd_sel;
      w_freq_nx     = r_freq_sel;
      w_req_nx      = r_freq_req;
      w_fault_nx    = r_fault;
      w_tgt_v_nx    = r_tgt_v;
      w_tgt_f_nx    = r_tgt_f;
      w_prev_f_nx   = r_prev_f;
      w_settle_load = 1'b0;
      w_to_load     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if ((req_voltage_i != r_vdd_sel) || (req_freq_i != r_freq_sel)) begin
               w_tgt_v_nx = req_voltage_i;
               w_tgt_f_nx = req_freq_i;
               if (req_voltage_i > r_vdd_sel) begin
                  w_vdd_nx      = req_voltage_i;
                  w_settle_load = 1'b1;
                  w_state_nx    = ST_V_UP;
               end else if (req_freq_i != r_freq_sel) begin
                  // F_REQ entry actions happen on the transition edge
                  w_freq_nx   = req_freq_i;
                  w_prev_f_nx = r_freq_sel;
                  w_req_nx    = 1'b1;
                  w_to_load   = 1'b1;
                  w_state_nx  = ST_F_REQ;
               end else begin
                  // voltage-only decrease: no frequency handshake needed
                  w_vdd_nx      = req_voltage_i;
                  w_settle_load = 1'b1;
                  w_state_nx    = ST_V_DN;
               end
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_V_UP: begin
            if (w_settle_done) begin
               if (r_tgt_f != r_freq_sel) begin
                  w_freq_nx   = r_tgt_f;
                  w_prev_f_nx = r_freq_sel;
                  w_req_nx    = 1'b1;
                  w_to_load   = 1'b1;
                  w_state_nx  = ST_F_REQ;
               end else begin
                  w_state_nx = ST_DONE;
               end
            end else begin
               w_state_nx = ST_V_UP;
            end
         end
         ST_F_REQ: begin
            // ack wins over a timeout landing in the same cycle
            if (freq_ack_i) begin
               w_req_nx = 1'b0;
               if (r_tgt_v < r_vdd_sel) begin
                  w_vdd_nx      = r_tgt_v;
                  w_settle_load = 1'b1;
                  w_state_nx    = ST_V_DN;
               end else begin
                  w_state_nx = ST_DONE;
               end
            end else if (w_to_done) begin
               w_freq_nx  = r_prev_f;
               w_req_nx   = 1'b0;
               w_fault_nx = 1'b1;
               w_state_nx = ST_DONE;
            end else begin
               w_state_nx = ST_F_REQ;
            end
         end
         ST_V_DN: begin
            if (w_settle_done) begin
               w_state_nx = ST_DONE;
            end else begin
               w_state_nx = ST_V_DN;
            end
         end
         ST_DONE: begin
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_req_nx   = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_vdd_sel  <= def_voltage_i;
         r_freq_sel <= def_freq_i;
         r_freq_req <= 1'b0;
         r_fault    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_tgt_v    <= {VOLT_W{1'b0}};
         r_tgt_f    <= {FREQ_W{1'b0}};
         r_prev_f   <= {FREQ_W{1'b0}};
      end else begin
         r_state    <= w_state_nx;
         r_vdd_sel  <= w_vdd_nx;
         r_freq_sel <= w_freq_nx;
         r_freq_req <= w_req_nx;
         r_fault    <= w_fault_nx;
         r_busy     <= (w_state_nx != ST_IDLE);
         r_done     <= (w_state_nx == ST_DONE);
         r_tgt_v    <= w_tgt_v_nx;
         r_tgt_f    <= w_tgt_f_nx;
         r_prev_f   <= w_prev_f_nx;
      end
   end

   assign vdd_sel_o  = r_vdd_sel;
   assign freq_sel_o = r_freq_sel;
   assign freq_req_o = r_freq_req;
   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign fault_o    = r_fault;

endmodule : cevero_vf_sequencer

// File: tb/tb_cevero_vf_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cevero_vf_sequencer
// Scenario tasks drive requests, push the expected end-of-sequence operating
// point to a scoreboard and pop it when done_o pulses; timing is checked inline.
// -----------------------------------------------------------------------------
module tb_cevero_vf_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [2:0]  req_voltage_i = 3'd5;
   logic [31:0] req_freq_i = 32'd150;
   logic [2:0]  def_voltage_i = 3'd5;
   logic [31:0] def_freq_i = 32'd150;
   logic [2:0]  vdd_sel_o;
   logic [31:0] freq_sel_o;
   logic        freq_req_o;
   logic        freq_ack_i = 1'b0;
   logic        busy_o;
   logic        done_o;
   logic        fault_o;

   typedef struct packed {
      logic [2:0]  v;
      logic [31:0] f;
      logic        fault;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   cevero_vf_sequencer #(
      .VOLT_W(3), .FREQ_W(32), .SETTLE_CYCLES(16), .ACK_TIMEOUT(64)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_voltage_i(req_voltage_i), .req_freq_i(req_freq_i),
      .def_voltage_i(def_voltage_i), .def_freq_i(def_freq_i),
      .vdd_sel_o(vdd_sel_o), .freq_sel_o(freq_sel_o),
      .freq_req_o(freq_req_o), .freq_ack_i(freq_ack_i),
      .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; def_voltage_i = 3'd5; def_freq_i = 32'd150;
      req_voltage_i = 3'd5; req_freq_i = 32'd150;
      tick(); tick();
      rst_i = 1'b0;
      checks++;
      if ({vdd_sel_o, freq_sel_o, busy_o, fault_o, freq_req_o, done_o} !==
          {3'd5, 32'd150, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_values: got v=%0d f=%0d busy=%b fault=%b req=%b done=%b, want v=5 f=150 all flags 0",
                  vdd_sel_o, freq_sel_o, busy_o, fault_o, freq_req_o, done_o);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({busy_o, done_o, vdd_sel_o, freq_sel_o} !== {1'b0, 1'b0, 3'd5, 32'd150}) begin
            failures++;
            $display("FAIL idle_hold: got busy=%b done=%b v=%0d f=%0d, want 0 0 5 150",
                     busy_o, done_o, vdd_sel_o, freq_sel_o);
         end
      end
   endtask

   task automatic test_v_up();
      exp_t e;
      req_voltage_i = 3'd6; req_freq_i = 32'd200;
      sb.push_back('{v: 3'd6, f: 32'd200, fault: 1'b0});
      tick();
      checks++;
      if ({vdd_sel_o, freq_sel_o, busy_o, freq_req_o} !== {3'd6, 32'd150, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL vup_first: got v=%0d f=%0d busy=%b req=%b, want 6 150 1 0",
                  vdd_sel_o, freq_sel_o, busy_o, freq_req_o);
      end
      for (int i = 1; i < 16; i++) begin
         tick();
         checks++;
         if ({freq_sel_o, freq_req_o} !== {32'd150, 1'b0}) begin
            failures++;
            $display("FAIL vup_settle: cycle %0d got f=%0d req=%b, want 150 0", i, freq_sel_o, freq_req_o);
         end
      end
      tick();
      checks++;
      if ({freq_sel_o, freq_req_o, vdd_sel_o} !== {32'd200, 1'b1, 3'd6}) begin
         failures++;
         $display("FAIL vup_freq_after_settle: got f=%0d req=%b v=%0d, want 200 1 6",
                  freq_sel_o, freq_req_o, vdd_sel_o);
      end
      tick(); tick();
      freq_ack_i = 1'b1;
      tick();
      freq_ack_i = 1'b0;
      checks++;
      if ({done_o, freq_req_o} !== {1'b1, 1'b0}) begin
         failures++;
         $display("FAIL vup_done: got done=%b req=%b, want 1 0", done_o, freq_req_o);
      end
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL vup_scoreboard: got empty queue, want one entry");
      end else begin
         e = sb.pop_front();
         if ({vdd_sel_o, freq_sel_o, fault_o} !== {e.v, e.f, e.fault}) begin
            failures++;
            $display("FAIL vup_result: got v=%0d f=%0d fault=%b, want v=%0d f=%0d fault=%b",
                     vdd_sel_o, freq_sel_o, fault_o, e.v, e.f, e.fault);
         end
      end
      tick();
      checks++;
      if ({done_o, busy_o} !== {1'b0, 1'b0}) begin
         failures++;
         $display("FAIL vup_single_pulse: got done=%b busy=%b, want 0 0", done_o, busy_o);
      end
   endtask

   task automatic test_v_down();
      exp_t e;
      req_voltage_i = 3'd4; req_freq_i = 32'd100;
      sb.push_back('{v: 3'd4, f: 32'd100, fault: 1'b0});
      tick();
      checks++;
      if ({freq_sel_o, freq_req_o, vdd_sel_o} !== {32'd100, 1'b1, 3'd6}) begin
         failures++;
         $display("FAIL vdn_freq_first: got f=%0d req=%b v=%0d, want 100 1 6",
                  freq_sel_o, freq_req_o, vdd_sel_o);
      end
      freq_ack_i = 1'b1;   // ack in the same cycle the request is visible
      tick();
      freq_ack_i = 1'b0;
      checks++;
      if ({vdd_sel_o, freq_req_o, done_o} !== {3'd4, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL vdn_volt_after_ack: got v=%0d req=%b done=%b, want 4 0 0",
                  vdd_sel_o, freq_req_o, done_o);
      end
      for (int i = 1; i < 16; i++) begin
         tick();
         checks++;
         if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL vdn_settle: cycle %0d got done=%b, want 0", i, done_o);
         end
      end
      tick();
      checks++;
      if (done_o !== 1'b1) begin
         failures++;
         $display("FAIL vdn_done: got done=%b, want 1", done_o);
      end else if (sb.size() == 0) begin
         failures++;
         $display("FAIL vdn_scoreboard: got empty queue, want one entry");
      end else begin
         e = sb.pop_front();
         if ({vdd_sel_o, freq_sel_o, fault_o} !== {e.v, e.f, e.fault}) begin
            failures++;
            $display("FAIL vdn_result: got v=%0d f=%0d fault=%b, want v=%0d f=%0d fault=%b",
                     vdd_sel_o, freq_sel_o, fault_o, e.v, e.f, e.fault);
         end
      end
      tick();
   endtask

   task automatic test_timeout();
      exp_t e;
      int   high_cnt;
      req_voltage_i = 3'd4; req_freq_i = 32'd120;
      sb.push_back('{v: 3'd4, f: 32'd100, fault: 1'b1});
      tick();
      high_cnt = 0;
      for (int i = 0; i < 200 && freq_req_o; i++) begin
         high_cnt++;
         tick();
      end
      checks++;
      if (high_cnt != 64) begin
         failures++;
         $display("FAIL timeout_req_len: got %0d cycles high, want 64", high_cnt);
      end
      checks++;
      if (done_o !== 1'b1) begin
         failures++;
         $display("FAIL timeout_done: got done=%b, want 1", done_o);
      end else if (sb.size() == 0) begin
         failures++;
         $display("FAIL timeout_scoreboard: got empty queue, want one entry");
      end else begin
         e = sb.pop_front();
         if ({vdd_sel_o, freq_sel_o, fault_o} !== {e.v, e.f, e.fault}) begin
            failures++;
            $display("FAIL timeout_result: got v=%0d f=%0d fault=%b, want v=%0d f=%0d fault=%b",
                     vdd_sel_o, freq_sel_o, fault_o, e.v, e.f, e.fault);
         end
      end
      req_freq_i = 32'd100;   // stop the sequencer from retrying
      tick(); tick(); tick();
      checks++;
      if ({fault_o, busy_o, done_o} !== {1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL timeout_sticky: got fault=%b busy=%b done=%b, want 1 0 0", fault_o, busy_o, done_o);
      end
   endtask

   task automatic test_change_during_vup();
      exp_t e;
      logic saw_req;
      req_voltage_i = 3'd6; req_freq_i = 32'd100;
      sb.push_back('{v: 3'd6, f: 32'd100, fault: 1'b1});
      tick(); tick(); tick();
      req_voltage_i = 3'd3;
      sb.push_back('{v: 3'd3, f: 32'd100, fault: 1'b1});
      for (int i = 0; i < 100 && !done_o; i++) tick();
      checks++;
      if (done_o !== 1'b1) begin
         failures++;
         $display("FAIL chg_first_done: got done=%b, want 1", done_o);
      end else begin
         e = sb.pop_front();
         if ({vdd_sel_o, freq_sel_o, fault_o} !== {e.v, e.f, e.fault}) begin
            failures++;
            $display("FAIL chg_first_result: got v=%0d f=%0d fault=%b, want v=%0d f=%0d fault=%b",
                     vdd_sel_o, freq_sel_o, fault_o, e.v, e.f, e.fault);
         end
      end
      tick();
      checks++;
      if ({busy_o, vdd_sel_o} !== {1'b0, 3'd6}) begin
         failures++;
         $display("FAIL chg_idle_gap: got busy=%b v=%0d, want 0 6", busy_o, vdd_sel_o);
      end
      tick();
      checks++;
      if ({busy_o, vdd_sel_o} !== {1'b1, 3'd3}) begin
         failures++;
         $display("FAIL chg_second_start: got busy=%b v=%0d, want 1 3", busy_o, vdd_sel_o);
      end
      saw_req = 1'b0;
      for (int i = 0; i < 100 && !done_o; i++) begin
         saw_req = saw_req | freq_req_o;
         tick();
      end
      checks++;
      if (done_o !== 1'b1 || saw_req !== 1'b0 || sb.size() == 0) begin
         failures++;
         $display("FAIL chg_second_done: got done=%b freq_req_seen=%b queue=%0d, want 1 0 1",
                  done_o, saw_req, sb.size());
      end else begin
         e = sb.pop_front();
         if ({vdd_sel_o, freq_sel_o, fault_o} !== {e.v, e.f, e.fault}) begin
            failures++;
            $display("FAIL chg_second_result: got v=%0d f=%0d fault=%b, want v=%0d f=%0d fault=%b",
                     vdd_sel_o, freq_sel_o, fault_o, e.v, e.f, e.fault);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      req_voltage_i = 3'd3; req_freq_i = 32'd140;
      tick();
      checks++;
      if (freq_req_o !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_in_freq: got req=%b, want 1", freq_req_o);
      end
      rst_i = 1'b1; def_voltage_i = 3'd2; def_freq_i = 32'd77;
      tick();
      checks++;
      if ({vdd_sel_o, freq_sel_o, freq_req_o, busy_o, done_o, fault_o} !==
          {3'd2, 32'd77, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL rstmid_values: got v=%0d f=%0d req=%b busy=%b done=%b fault=%b, want 2 77 0 0 0 0",
                  vdd_sel_o, freq_sel_o, freq_req_o, busy_o, done_o, fault_o);
      end
      rst_i = 1'b0; req_voltage_i = 3'd2; req_freq_i = 32'd77;
      tick(); tick();
      checks++;
      if ({busy_o, sb.size() == 0} !== {1'b0, 1'b1}) begin
         failures++;
         $display("FAIL rstmid_after: got busy=%b queue=%0d, want 0 0", busy_o, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_v_up();
      test_v_down();
      test_timeout();
      test_change_during_vup();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000 ns, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_cevero_vf_sequencer

// File: doc/cevero_vf_sequencer.md
Name: cevero_vf_sequencer

Overview:
Downstream stage of cevero_dvfs. Consumes its set_voltage_o / set_freq_o requests and applies them to the voltage regulator select and the clock generator in a safe order. Voltage increases go voltage-first, then frequency after a settle delay. Decreases go frequency-first, then voltage. Frequency changes use a req/ack handshake with the clock generator, protected by a timeout.

Parameters:
VOLT_W, 3, width of voltage code
FREQ_W, 32, width of frequency word
SETTLE_CYCLES, 16, regulator settle time in clk cycles after any vdd_sel_o change (legal range >= 1)
ACK_TIMEOUT, 64, max cycles freq_req_o may stay high without freq_ack_i (legal range >= 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_voltage_i  in  VOLT_W  target voltage code (from cevero_dvfs set_voltage_o)
req_freq_i  in  FREQ_W  target frequency (from cevero_dvfs set_freq_o)
def_voltage_i  in  VOLT_W  voltage applied at reset
def_freq_i  in  FREQ_W  frequency applied at reset
vdd_sel_o  out  VOLT_W  applied voltage code to regulator
freq_sel_o  out  FREQ_W  applied frequency word to clock generator
freq_req_o  out  1  frequency change request, level, held until ack or timeout
freq_ack_i  in  1  clock generator lock/accept
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse when a sequence completes
fault_o  out  1  sticky; set on ack timeout, cleared only by rst_i

Behaviour:
- Clock and reset: one clock (clk_i). Reset is synchronous and active-high (rst_i). All outputs are registered.
- Reset values:
  - vdd_sel_o = def_voltage_i and freq_sel_o = def_freq_i, sampled while rst_i is high.
  - freq_req_o, busy_o, done_o, fault_o = 0; state = IDLE; counters = 0.
- Reset mid-sequence aborts immediately to the reset values. No ordering is enforced during reset.
- IDLE:
  - If req_voltage_i == vdd_sel_o and req_freq_i == freq_sel_o, stay.
  - Otherwise latch tgt_v and tgt_f (requests are ignored until the next IDLE).
  - If tgt_v > vdd_sel_o (unsigned): vdd_sel_o <= tgt_v, load settle counter, go V_UP.
  - Else: go F_REQ.
- V_UP:
  - Counter decrements each cycle. Exactly SETTLE_CYCLES cycles are spent in V_UP.
  - Then go F_REQ if tgt_f != freq_sel_o, else DONE.
- F_REQ:
  - On entry: freq_sel_o <= tgt_f, freq_req_o <= 1; the previous frequency is saved in prev_f.
  - freq_req_o stays high until freq_ack_i is sampled high; then freq_req_o <= 0.
  - After ack: if tgt_v < vdd_sel_o, vdd_sel_o <= tgt_v, load settle counter, go V_DN. Else go DONE.
  - An ack arriving in the same cycle the request is raised counts.
  - Timeout: after ACK_TIMEOUT cycles without ack, freq_sel_o <= prev_f, freq_req_o <= 0, fault_o <= 1, go DONE. The voltage is not lowered.
- V_DN: SETTLE_CYCLES cycles, then go DONE.
- DONE: done_o = 1 for this single cycle, then go IDLE.
  - A new mismatch is evaluated in IDLE on the following cycle, so at least one IDLE cycle occurs between sequences.
- Voltage-only or frequency-only changes skip the unneeded states. A frequency-only change enters F_REQ directly. Equal voltage means no settle.
- freq_ack_i outside F_REQ is ignored.
- Comparisons are unsigned. The settle counter is $clog2(SETTLE_CYCLES+1) bits; the timeout counter is $clog2(ACK_TIMEOUT+1) bits. Neither counter wraps: both saturate at the terminal condition.

Decomposition:
- cevero_dvfs_pkg: state enum (IDLE, V_UP, F_REQ, V_DN, DONE), default VOLT_W/FREQ_W constants.
- One sub-module, cevero_settle_timer: load/count-down timer with done flag.
  - Instantiated twice: settle delay and ack timeout (param width).

Test Plan:
- Reset with def v=5, f=150 -> vdd_sel_o=5, freq_sel_o=150, busy_o=0, fault_o=0. Holding req v=5, f=150 afterwards -> stays IDLE, no done_o.
- req v=6, f=200, SETTLE=16, ack 3 cycles after req:
  - vdd_sel_o=6 one cycle after mismatch.
  - freq_sel_o=200 and freq_req_o high exactly 16 cycles later.
  - Single done_o after ack.
- From v=6, f=200, request v=4, f=100:
  - freq_sel_o=100 first, with vdd_sel_o still 6 until ack.
  - vdd_sel_o=4 the cycle after ack, then 16 settle cycles, then done_o.
- Request f=120, voltage unchanged, ack never asserted, ACK_TIMEOUT=64:
  - freq_req_o high 64 cycles.
  - freq_sel_o returns to previous value, fault_o=1 sticky, done_o pulse.
- Change req inputs during V_UP -> ignored until done_o; the new values are then sequenced from IDLE.
- Assert rst_i during F_REQ -> the next cycle shows all reset values and freq_req_o=0.
